// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemming array and the dig scheduler:
// scheduler state type, counter width and the lemming FSM state codes.
package lemmings_pkg;

    // Width of the shovel budget, timers and statistics counters
    localparam int CNT_W = 8;

    // Dig scheduler states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_HOLD     = 2'd2,
        ST_COOLDOWN = 2'd3
    } sched_state_t;

    // Lemming FSM state encodings, shared with the lemming block
    localparam logic [2:0] LEM_WALK_L = 3'd0;
    localparam logic [2:0] LEM_WALK_R = 3'd1;
    localparam logic [2:0] LEM_FALL_L = 3'd2;
    localparam logic [2:0] LEM_FALL_R = 3'd3;
    localparam logic [2:0] LEM_DIG_L  = 3'd4;
    localparam logic [2:0] LEM_DIG_R  = 3'd5;
    localparam logic [2:0] LEM_SPLAT  = 3'd6;

endpackage

// File: rtl/lemmings_dig_scheduler_rr_arbiter.sv
// Combinational N-way round-robin picker: returns the first eligible
// index at or after the pointer, wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] pointer,
    output logic                 any,
    output logic [$clog2(N)-1:0] winner
);

    localparam int IW = $clog2(N);

    // Scan upward from the pointer; the first hit wins
    always_comb begin
        int j;
        any    = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(pointer) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && eligible[j]) begin
                any    = 1'b1;
                winner = IW'(j);
            end
        end
    end

endmodule

// File: rtl/lemmings_dig_scheduler.sv
// Shares one shovel between N lemmings: grants dig requests round-robin,
// watches the grantee's digging/aaah/walk outputs, enforces a global
// budget of successful digs and a cooldown between uses.
// Optional build macro DIG_STATS_EN adds dig_count / abort_count outputs.
module lemmings_dig_scheduler
    import lemmings_pkg::*;
#(
    parameter int N             = 4,
    parameter int BUDGET        = 10,
    parameter int ISSUE_TIMEOUT = 8,
    parameter int COOLDOWN      = 3
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lem_walking,
    input  logic [N-1:0]         lem_aaah,
    input  logic [N-1:0]         lem_digging,
    output logic [N-1:0]         dig,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [7:0]           shovels_left,
`ifdef DIG_STATS_EN
    output logic [7:0]           dig_count,
    output logic [7:0]           abort_count,
`endif
    output logic                 exhausted
);

    localparam int IW = $clog2(N);
    localparam logic [CNT_W-1:0] BUDGET_INIT = CNT_W'(BUDGET);
    localparam logic [CNT_W-1:0] ISSUE_LAST  = CNT_W'(ISSUE_TIMEOUT - 1);
    // COOLDOWN of 0 or 1 both spend exactly one cycle in the cooldown state
    localparam logic [CNT_W-1:0] COOL_LAST   = (COOLDOWN == 0) ? '0 : CNT_W'(COOLDOWN - 1);

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    sched_state_t     state;
    logic [IW-1:0]    rr_ptr;
    logic [CNT_W-1:0] timer;
    logic [N-1:0]     eligible;
    logic             any;
    logic [IW-1:0]    winner;
    logic             g_digging;
    logic             g_alive;
    logic             g_aaah;
    logic             issue_hold;
    logic             issue_abort;

    assign eligible  = req & lem_walking;
    assign g_digging = lem_digging[grant_idx];
    assign g_aaah    = lem_aaah[grant_idx];
    assign g_alive   = lem_walking[grant_idx] | g_aaah | g_digging;

    // Digging takes priority over every abort condition in the same cycle
    assign issue_hold  = (state == ST_ISSUE) && g_digging;
    assign issue_abort = (state == ST_ISSUE) && !g_digging &&
                         (!g_alive || g_aaah || (timer == ISSUE_LAST));

    assign busy      = (state == ST_ISSUE) || (state == ST_HOLD);
    assign exhausted = (shovels_left == '0);

    rr_arbiter #(.N(N)) u_arb (
        .eligible (eligible),
        .pointer  (rr_ptr),
        .any      (any),
        .winner   (winner)
    );

    // Scheduler FSM; dig is registered so it is one-hot-or-zero and glitch free
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state        <= ST_IDLE;
            dig          <= '0;
            grant_idx    <= '0;
            rr_ptr       <= '0;
            shovels_left <= BUDGET_INIT;
            timer        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!exhausted && any) begin
                        grant_idx <= winner;
                        rr_ptr    <= (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
                        dig       <= {{(N-1){1'b0}}, 1'b1} << winner;
                        timer     <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_hold) begin
                        dig          <= '0;
                        shovels_left <= sat_dec(shovels_left);
                        state        <= ST_HOLD;
                    end else if (issue_abort) begin
                        dig   <= '0;
                        timer <= '0;
                        state <= ST_COOLDOWN;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!g_digging) begin
                        timer <= '0;
                        state <= ST_COOLDOWN;
                    end
                end
                default: begin
                    if (timer >= COOL_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef DIG_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Saturating counts of successful dig starts and abandoned grants
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            dig_count   <= '0;
            abort_count <= '0;
        end else begin
            if (issue_hold)  dig_count   <= sat_inc(dig_count);
            if (issue_abort) abort_count <= sat_inc(abort_count);
        end
    end
`endif

endmodule

// File: tb/tb_lemmings_dig_scheduler.sv
// Directed bench for lemmings_dig_scheduler (N=4, BUDGET=10, timeout 8,
// cooldown 3). Expected values are hand-derived from the scheduler rules.
module tb_lemmings_dig_scheduler;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] lem_walking = '0;
    logic [3:0] lem_aaah = '0;
    logic [3:0] lem_digging = '0;
    logic [3:0] dig;
    logic       busy;
    logic [1:0] grant_idx;
    logic [7:0] shovels_left;
    logic       exhausted;
`ifdef DIG_STATS_EN
    logic [7:0] dig_count;
    logic [7:0] abort_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lemmings_dig_scheduler #(
        .N(4), .BUDGET(10), .ISSUE_TIMEOUT(8), .COOLDOWN(3)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .req          (req),
        .lem_walking  (lem_walking),
        .lem_aaah     (lem_aaah),
        .lem_digging  (lem_digging),
        .dig          (dig),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .shovels_left (shovels_left),
`ifdef DIG_STATS_EN
        .dig_count    (dig_count),
        .abort_count  (abort_count),
`endif
        .exhausted    (exhausted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clock edges until dig goes non-zero (bounded at 40)
    task automatic wait_grant(output int n);
        n = 0;
        while (dig == 4'b0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Samples for which dig stays non-zero, starting with the current one
    task automatic count_high(output int n);
        n = 0;
        while (dig != 4'b0 && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        logic [3:0] onehot;
        int g;

        // Reset state
        #1 areset = 1'b1;
        #10;
        check("rst_dig", dig, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_idx, 2'd0);
        check("rst_left", shovels_left, 8'd10);
        check("rst_exh", exhausted, 1'b0);
        areset = 1'b0;
        tick();

        // Grant 1 from req 0110, lemming 1 starts digging on its second dig cycle
        lem_walking = 4'hF;
        req = 4'b0110;
        tick();
        check("t1_dig_a", dig, 4'b0010);
        check("t1_busy", busy, 1'b1);
        check("t1_gidx", grant_idx, 2'd1);
        tick();
        check("t1_dig_b", dig, 4'b0010);
        lem_digging = 4'b0010;
        lem_walking = 4'b1101;
        tick();
        check("t1_hold_dig", dig, 4'b0000);
        check("t1_hold_busy", busy, 1'b1);
        check("t1_left", shovels_left, 8'd9);
        tick();
        check("t1_hold2_busy", busy, 1'b1);
        lem_digging = 4'b0000;
        lem_walking = 4'hF;
        tick();
        check("t1_cool_busy", busy, 1'b0);
        // three cooldown cycles then the IDLE grant cycle
        wait_grant(n);
        check("t1_gap", n, 4);
        check("t1_next_dig", dig, 4'b0100);
        check("t1_next_gidx", grant_idx, 2'd2);

        // Grantee 2 never digs: timeout after 8 dig cycles
        count_high(n);
        check("t2_high_len", n, 8);
        check("t2_left", shovels_left, 8'd9);
        check("t2_busy", busy, 1'b0);
        wait_grant(n);
        check("t2_gap", n, 4);
        check("t2_next_gidx", grant_idx, 2'd1);
        check("t2_next_dig", dig, 4'b0010);

        // Grantee 1 falls (aaah) on its third ISSUE cycle
        tick();
        tick();
        check("t3_dig_c3", dig, 4'b0010);
        lem_aaah = 4'b0010;
        lem_walking = 4'b1101;
        tick();
        check("t3_abort_dig", dig, 4'b0000);
        check("t3_abort_busy", busy, 1'b0);
        check("t3_left", shovels_left, 8'd9);
        lem_aaah = 4'b0000;
        lem_walking = 4'hF;
        wait_grant(n);
        check("t3_gap", n, 4);
        check("t3_next_gidx", grant_idx, 2'd2);

        // Digging rises on the same cycle the timeout expires: digging wins
        for (int i = 0; i < 7; i++) tick();
        check("t5_dig_last", dig, 4'b0100);
        lem_digging = 4'b0100;
        lem_walking = 4'b1011;
        tick();
        check("t5_dig", dig, 4'b0000);
        check("t5_busy", busy, 1'b1);
        check("t5_left", shovels_left, 8'd8);
        lem_digging = 4'b0000;
        lem_walking = 4'hF;
        tick();
        wait_grant(n);
        check("t5_next_gidx", grant_idx, 2'd1);

        // Grantee 1 dies (all outputs low): abort, no decrement
        lem_walking = 4'b1101;
        tick();
        check("t6_busy", busy, 1'b0);
        check("t6_left", shovels_left, 8'd8);
        lem_walking = 4'hF;
        req = 4'hF;

        // Drain the remaining 8 shovels with all lemmings requesting
        for (int k = 0; k < 8; k++) begin
            wait_grant(n);
            g = (2 + k) % 4;
            onehot = 4'b0001 << g;
            check("t4_gidx", grant_idx, g);
            check("t4_dig", dig, onehot);
            lem_digging = onehot;
            lem_walking = 4'hF & ~onehot;
            tick();
            check("t4_left", shovels_left, 7 - k);
            lem_digging = 4'b0000;
            lem_walking = 4'hF;
            tick();
        end
        check("t4_exh", exhausted, 1'b1);
        wait_grant(n);
        check("t4_no_grant", n, 40);
        check("t4_no_dig", dig, 4'b0000);
`ifdef DIG_STATS_EN
        check("st_digs", dig_count, 8'd10);
        check("st_aborts", abort_count, 8'd3);
`endif

        // Reset reloads the budget; then async reset during HOLD
        #2 areset = 1'b1;
        #1;
        check("r_left", shovels_left, 8'd10);
        check("r_exh", exhausted, 1'b0);
        #1 areset = 1'b0;
        tick();
        check("r_gidx", grant_idx, 2'd0);
        check("r_dig", dig, 4'b0001);
        lem_digging = 4'b0001;
        lem_walking = 4'b1110;
        tick();
        check("r_hold_left", shovels_left, 8'd9);
        #3 areset = 1'b1;
        #1;
        check("r_hold_dig", dig, 4'b0000);
        check("r_hold_busy", busy, 1'b0);
        check("r_hold_left2", shovels_left, 8'd10);
`ifdef DIG_STATS_EN
        check("r_st_digs", dig_count, 8'd0);
`endif
        #1 areset = 1'b0;
        lem_digging = 4'b0000;
        lem_walking = 4'hF;
        tick();
        check("r2_dig", dig, 4'b0001);
        #3 areset = 1'b1;
        #1;
        check("r2_issue_dig", dig, 4'b0000);
        check("r2_issue_busy", busy, 1'b0);
        #1 areset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
